// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the two-requester SRAM port controller: FSM encoding,
// requester ids and default bus widths.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    typedef logic req_id_t;
    localparam req_id_t M0 = 1'b0;
    localparam req_id_t M1 = 1'b1;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 3;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side handshake bundle: one instance per requester (m0, m1).
interface sram_port_arbiter_if
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();
    logic                  valid;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ready;
    logic                  done;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output valid, we, addr, wdata, input  ready, done, rdata);
    modport slave  (input  valid, we, addr, wdata, output ready, done, rdata);
endinterface

// File: rtl/sram_port_arbiter_rr.sv
// Two-way grant logic. Round-robin by default; defining SRAM_ARB_FIXED_PRIO_EN
// switches to fixed priority (m0 always wins, m1 can starve).
module sram_rr_arbiter
    import sram_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_gnt0,
    output logic o_gnt1
);
    logic w_pick1;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign w_pick1 = i_req1 && !i_req0;
`else
    req_id_t r_rr_last;

    // On a tie the requester that did not win last time is picked.
    assign w_pick1 = i_req1 && (!i_req0 || (r_rr_last == M0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_last <= M1;
        end else if (i_en && (i_req0 || i_req1)) begin
            r_rr_last <= w_pick1 ? M1 : M0;
        end
    end
`endif

    assign o_gnt1 = i_en && w_pick1;
    assign o_gnt0 = i_en && i_req0 && !w_pick1;

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one asynchronous single-port SRAM between two requesters, sequencing
// SETUP/ACCESS/HOLD around every strobe. Optional: SRAM_ARB_FIXED_PRIO_EN.
module sram_port_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int WR_CYCLES  = 1,
    parameter int RD_CYCLES  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sram_port_arbiter_if.slave    m0,
    sram_port_arbiter_if.slave    m1,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    inout  wire  [DATA_WIDTH-1:0] sram_data,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic                  sram_oe
);
    localparam int CNT_W = $clog2(max2(WR_CYCLES, RD_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_run;
    logic                  r_wr;
    req_id_t               r_id;
    logic                  r_drive;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata0, r_rdata1;
    logic                  r_done0, r_done1;
    logic                  r_cs, r_we, r_oe;

    logic w_en, w_gnt0, w_gnt1, w_accept;

    // r_run keeps ready low while reset is asserted even if a valid is already up.
    assign w_en     = (r_state == ST_IDLE) && r_run;
    assign w_accept = w_gnt0 || w_gnt1;

    sram_rr_arbiter u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_en),
        .i_req0 (m0.valid),
        .i_req1 (m1.valid),
        .o_gnt0 (w_gnt0),
        .o_gnt1 (w_gnt1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_run    <= 1'b0;
            r_wr     <= 1'b0;
            r_id     <= M0;
            r_drive  <= 1'b0;
            r_addr   <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_cs     <= 1'b0;
            r_we     <= 1'b0;
            r_oe     <= 1'b0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_id    <= w_gnt1 ? M1 : M0;
                        r_addr  <= w_gnt1 ? m1.addr : m0.addr;
                        r_wr    <= w_gnt1 ? m1.we : m0.we;
                        r_drive <= w_gnt1 ? m1.we : m0.we;
                        r_cs    <= 1'b1;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_cnt   <= r_wr ? WR_LOAD : RD_LOAD;
                    r_we    <= r_wr;
                    r_oe    <= !r_wr;
                    r_state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (r_cnt == '0) begin
                        r_we    <= 1'b0;
                        r_oe    <= 1'b0;
                        r_done0 <= (r_id == M0);
                        r_done1 <= (r_id == M1);
                        if (!r_wr && r_id == M0) r_rdata0 <= sram_data;
                        if (!r_wr && r_id == M1) r_rdata1 <= sram_data;
                        r_state <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                    r_cs    <= 1'b0;
                    r_drive <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Write data only matters while r_drive is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_accept) r_wdata <= w_gnt1 ? m1.wdata : m0.wdata;
    end

    assign sram_data = r_drive ? r_wdata : {DATA_WIDTH{1'bz}};
    assign sram_addr = r_addr;
    assign sram_cs   = r_cs;
    assign sram_we   = r_we;
    assign sram_oe   = r_oe;

    assign m0.ready = w_gnt0;
    assign m1.ready = w_gnt1;
    assign m0.done  = r_done0;
    assign m1.done  = r_done1;
    assign m0.rdata = r_rdata0;
    assign m1.rdata = r_rdata1;

endmodule
